// File: rtl/fetch_controller_pkg.sv
// Shared pipeline package: fetch FSM state encoding, PC/instruction widths
// and the default halt encoding used by the fetch stage.
package fetch_controller_pkg;

  localparam int PC_W    = 6;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 32'hFC00_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// three-state (IDLE/RUN/HALTED) control FSM. Instruction memory is external
// and read combinationally at instruction_address.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   start                leave IDLE and begin fetching at the current PC
//   stall                hold PC and IF/ID register
//   redirect_valid/target taken branch/jump from a later stage
//   instruction_address  memory read address (= pc_q)
//   instruction          memory read data
//   if_instruction/if_pc/if_valid  IF/ID register
//   halted               high in HALTED
//   fetch_count          delivered-instruction count, saturating
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = 6'd0,
  parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  output logic [PC_W-1:0]    instruction_address,
  input  logic [INSTR_W-1:0] instruction,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [PC_W-1:0]    if_pc,
  output logic               if_valid,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  fetch_state_e        state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_d;
  logic [PC_W-1:0]     if_pc_d;
  logic                valid_d;
  logic [15:0]         cnt_d;

  assign instruction_address = pc_q;
  assign halted              = (state_q == ST_HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      pc_q           <= RESET_PC;
      if_instruction <= '0;
      if_pc          <= '0;
      if_valid       <= 1'b0;
      fetch_count    <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      if_instruction <= instr_d;
      if_pc          <= if_pc_d;
      if_valid       <= valid_d;
      fetch_count    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = if_instruction;
    if_pc_d = if_pc;
    valid_d = if_valid;
    cnt_d   = fetch_count;
    unique case (state_q)
      ST_IDLE: begin
        // redirects are ignored until fetch has been started
        valid_d = 1'b0;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          // redirect beats stall and halt: squash this fetch, one bubble
          pc_d    = redirect_target;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d = instruction;
          if_pc_d = pc_q;
          valid_d = 1'b1;
          if (fetch_count != 16'hFFFF) cnt_d = fetch_count + 16'd1;
          // halt word is delivered, but the PC parks on its address
          if (instruction == HALT_WORD) state_d = ST_HALTED;
          else                          pc_d    = pc_q + 6'd1;
        end
      end
      ST_HALTED: begin
        if (redirect_valid) begin
          pc_d    = redirect_target;
          valid_d = 1'b0;
          state_d = ST_RUN;
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 6'd0: the PC value loaded on reset.
REQ-002 Parameter HALT_WORD, default 32'hFC00_0000: the instruction encoding that stops fetch.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  leaves IDLE and begins fetching at the current PC.
REQ-006 stall  input  1  holds the PC and the IF/ID outputs.
REQ-007 redirect_valid  input  1  taken branch or jump from a later stage.
REQ-008 redirect_target  input  6  word address to fetch after a redirect.
REQ-009 instruction_address  output  6  read address to instruction memory, equal to pc_q.
REQ-010 instruction  input  32  combinational read data from instruction memory.
REQ-011 if_instruction  output  32  registered IF/ID instruction.
REQ-012 if_pc  output  6  registered address of if_instruction.
REQ-013 if_valid  output  1  if_instruction is a real fetch (not a bubble).
REQ-014 halted  output  1  high while in state HALTED.
REQ-015 fetch_count  output  16  number of instructions delivered with if_valid=1; saturates at 16'hFFFF.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and HALTED.
REQ-017 In IDLE, the block SHALL:
- drive instruction_address=pc_q and hold pc_q;
- drive if_valid=0;
- move to RUN on the next edge after start=1.
REQ-018 In RUN with stall=0 and redirect_valid=0, each edge SHALL:
- load if_instruction with instruction;
- load if_pc with pc_q;
- set if_valid=1;
- set pc_q to pc_q+1.
REQ-019 Latency: instruction data at address A SHALL appear on if_instruction one edge after instruction_address=A.
REQ-020 The PC SHALL wrap modulo 64, so 63 is followed by 0, with no flag or stall.
REQ-021 In RUN with stall=1 and redirect_valid=0, the block SHALL hold pc_q, if_instruction, if_pc, if_valid and fetch_count.
REQ-022 When redirect_valid=1, in RUN or HALTED and regardless of stall, the next edge SHALL:
- set pc_q to redirect_target;
- set if_valid=0, squashing the current fetch;
- enter RUN if the block was in HALTED.
REQ-023 Redirect SHALL take priority over both stall and halt detection; exactly one bubble follows each redirect.
REQ-024 redirect_valid SHALL be ignored in IDLE.
REQ-025 In RUN, no stall and no redirect, an instruction equal to HALT_WORD SHALL be delivered normally (if_valid=1, counted), pc_q SHALL NOT increment, and the state SHALL move to HALTED.
REQ-026 In HALTED with no redirect:
- if_valid SHALL drop to 0 on the first edge with stall=0;
- while stall=1, the IF/ID outputs SHALL hold;
- pc_q SHALL stay at the halt instruction's address.
REQ-027 fetch_count SHALL increment on every edge that loads if_valid=1, and SHALL stop incrementing at 16'hFFFF.
REQ-028 start SHALL be ignored outside IDLE.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately, without a clock, set:
- state=IDLE, pc_q=RESET_PC;
- if_instruction=32'h0, if_pc=6'h0, if_valid=0;
- halted=0, fetch_count=0.
REQ-030 Reset mid-RUN SHALL discard any in-flight fetch; the first edge after deassertion SHALL leave the block in IDLE.

Structure
REQ-031 The state encoding typedef, PC width (6), instruction width (32) and HALT_WORD default SHALL live in the shared pipeline package.
REQ-032 The block SHALL be a single module with no sub-modules; the instruction memory stays external.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Reset, start, memory[0..3]=10,11,12,13 -> if_pc 0,1,2,3 on consecutive edges with if_valid=1; fetch_count=4 after 4 edges.
- Stall for 3 cycles at PC=5 -> if_pc, if_instruction and fetch_count unchanged; PC=6 fetched on the first edge after release.
- Redirect to 40 while fetching 7 -> one if_valid=0 bubble, then if_pc=40; 7 is never delivered.
- Simultaneous stall=1 and redirect to 20 -> bubble, then if_pc=20 (redirect wins).
- HALT_WORD at address 9 -> if_pc=9 with if_valid=1, then halted=1 and if_valid=0; a redirect to 0 resumes with if_pc=0.
- Start at PC=63 with memory[63]=1, memory[0]=2 -> if_pc 63 then 0; rst_n pulled low mid-run -> outputs cleared asynchronously and state IDLE.
